// File: rtl/spi_slave_byte.sv
// spi_slave_byte: SPI mode-0 slave byte front end with oversampled inputs and a pending tx byte.
// Optional frame error reporting is enabled with `define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_byte #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic       frame_err,
    output logic [7:0] err_cnt
`endif
);
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic sclk_prev_q, cs_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic rx_valid_q, rx_valid_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic miso_q, miso_d;
    logic [7:0] pend_q, pend_d;
    logic pend_full_q, pend_full_d;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, active, boundary, capture;
    logic [7:0] reload_byte;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
`endif

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev_q;
    assign sclk_fall = !sclk_s && sclk_prev_q;
    assign cs_fall   = cs_prev_q && !cs_s;
    assign cs_rise   = !cs_prev_q && cs_s;
    assign active    = !cs_s;

    always_comb begin
        reload_byte = pend_full_q ? pend_q : IDLE_BYTE;
        // A session start is also a byte boundary: both load the next outgoing byte
        boundary    = cs_fall || (active && sclk_fall && bit_cnt_q == 3'd0);
        capture     = active && !cs_fall && sclk_rise;
        tx_shift_d  = boundary ? reload_byte
                    : (active && sclk_fall) ? {tx_shift_q[6:0], 1'b0} : tx_shift_q;
        miso_d      = cs_rise ? 1'b0
                    : (boundary || (active && sclk_fall)) ? tx_shift_d[7] : miso_q;
        bit_cnt_d   = (cs_fall || cs_rise) ? 3'd0 : capture ? bit_cnt_q + 3'd1 : bit_cnt_q;
        rx_shift_d  = capture ? {rx_shift_q[5:0], mosi_s} : rx_shift_q;
        rx_valid_d  = capture && bit_cnt_q == 3'd7;
        rx_data_d   = rx_valid_d ? {rx_shift_q, mosi_s} : rx_data_q;
        // A strobe coinciding with a reload survives for the following boundary
        pend_d      = tx_valid ? tx_data : pend_q;
        pend_full_d = tx_valid || (pend_full_q && !boundary);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = cs_rise && bit_cnt_q != 3'd0;
        err_cnt_d   = (frame_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= IDLE_BYTE;
            miso_q      <= 1'b0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
`endif
endmodule
